// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear frequency-sweep controller feeding a DDS phase
// accumulator. It steps the tuning word from f_start to f_stop, holding each
// value for a programmable dwell, in single, sawtooth or triangle mode.
// Optional build macro DDS_SWEEP_MARKER_EN adds a marker_freq input and a
// marker output that pulses when the tuning word crosses marker_freq.
module dds_sweep_ctrl #(
  parameter int FW = 32,
  parameter int PW = 12,
  parameter int DW = 24
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  input  logic [PW-1:0] p_offset,
`ifdef DDS_SWEEP_MARKER_EN
  input  logic [FW-1:0] marker_freq,
  output logic          marker,
`endif
  output logic [FW-1:0] Fword,
  output logic [PW-1:0] Pword,
  output logic          busy,
  output logic          step_tick,
  output logic          sweep_done,
  output logic          cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_mode;
  logic [FW-1:0] r_fstart;
  logic [FW-1:0] r_fstop;
  logic [FW-1:0] r_fstep;
  logic [DW-1:0] r_dwell_last;
  logic [DW-1:0] r_cnt;
  logic          r_wrap;
  logic [FW-1:0] r_fword;
  logic [PW-1:0] r_pword;
  logic          r_busy;
  logic          r_tick;
  logic          r_done;
  logic          r_cfg_err;

  logic          w_expire;
  logic [FW:0]   w_sum;
  logic          w_up_end;
  logic [FW-1:0] w_up_next;
  logic          w_dn_end;
  logic [FW-1:0] w_dn_next;
  logic          w_step_zero;

  // Last counter value of a dwell period; a dwell of 0 behaves like 1.
  function automatic logic [DW-1:0] dwell_last(input logic [DW-1:0] d);
    logic [DW-1:0] last;
    last = '0;
    if (d != '0) last = d - {{(DW-1){1'b0}}, 1'b1};
    return last;
  endfunction

  // Step arithmetic is carried one bit wider so the top end never wraps.
  always_comb begin
    w_expire    = (r_cnt == r_dwell_last);
    w_sum       = {1'b0, r_fword} + {1'b0, r_fstep};
    w_up_end    = (w_sum >= {1'b0, r_fstop});
    w_up_next   = w_up_end ? r_fstop : w_sum[FW-1:0];
    w_dn_end    = ({1'b0, r_fword} <= ({1'b0, r_fstart} + {1'b0, r_fstep}));
    w_dn_next   = w_dn_end ? r_fstart : (r_fword - r_fstep);
    w_step_zero = (r_fstep == '0);
  end

`ifdef DDS_SWEEP_MARKER_EN
  logic r_marker;

  // Pulse when a sweep step carries the tuning word across marker_freq.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_marker <= 1'b0;
    end else begin
      r_marker <= 1'b0;
      if (!abort && w_expire && !r_wrap) begin
        if (r_state == UP)
          r_marker <= (r_fword < marker_freq) && (marker_freq <= w_up_next);
        else if (r_state == DOWN)
          r_marker <= (r_fword > marker_freq) && (marker_freq >= w_dn_next);
      end
    end
  end

  assign marker = r_marker;
`endif

  // Sweep state machine; all status outputs are registered here.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mode       <= 2'b00;
      r_fstart     <= '0;
      r_fstop      <= '0;
      r_fstep      <= '0;
      r_dwell_last <= '0;
      r_cnt        <= '0;
      r_wrap       <= 1'b0;
      r_fword      <= '0;
      r_pword      <= '0;
      r_busy       <= 1'b0;
      r_tick       <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_pword   <= p_offset;
      r_tick    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_wrap  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            // busy lingers one cycle after a single sweep finishes
            r_busy <= 1'b0;
            if (start && !r_busy) begin
              if (f_stop > f_start) begin
                r_mode       <= mode;
                r_fstart     <= f_start;
                r_fstop      <= f_stop;
                r_fstep      <= f_step;
                r_dwell_last <= dwell_last(dwell);
                r_fword      <= f_start;
                r_cnt        <= '0;
                r_wrap       <= 1'b0;
                r_busy       <= 1'b1;
                r_state      <= UP;
              end else begin
                r_cfg_err <= 1'b1;
              end
            end
          end
          UP: begin
            if (w_expire) begin
              r_cnt <= '0;
              if (r_wrap) begin
                // sawtooth: restart the ramp after holding f_stop
                r_fword <= r_fstart;
                r_tick  <= 1'b1;
                r_wrap  <= 1'b0;
              end else begin
                r_fword <= w_up_next;
                r_tick  <= !w_step_zero;
                if (w_up_end) begin
                  case (r_mode)
                    2'b10: r_state <= DOWN;
                    2'b01: begin
                      r_done <= 1'b1;
                      r_wrap <= 1'b1;
                    end
                    default: begin
                      r_done  <= 1'b1;
                      r_state <= IDLE;
                    end
                  endcase
                end
              end
            end else begin
              r_cnt <= r_cnt + {{(DW-1){1'b0}}, 1'b1};
            end
          end
          DOWN: begin
            if (w_expire) begin
              r_cnt   <= '0;
              r_fword <= w_dn_next;
              r_tick  <= 1'b1;
              if (w_dn_end) begin
                r_done  <= 1'b1;
                r_state <= UP;
              end
            end else begin
              r_cnt <= r_cnt + {{(DW-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Fword      = r_fword;
  assign Pword      = r_pword;
  assign busy       = r_busy;
  assign step_tick  = r_tick;
  assign sweep_done = r_done;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl (default build, marker feature absent).
module tb_dds_sweep_ctrl;

  localparam int FW = 32;
  localparam int PW = 12;
  localparam int DW = 24;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [FW-1:0] f_start;
  logic [FW-1:0] f_stop;
  logic [FW-1:0] f_step;
  logic [DW-1:0] dwell;
  logic [PW-1:0] p_offset;
  logic [FW-1:0] Fword;
  logic [PW-1:0] Pword;
  logic          busy;
  logic          step_tick;
  logic          sweep_done;
  logic          cfg_err;

  int vectors    = 0;
  int miscompares = 0;

  dds_sweep_ctrl #(.FW(FW), .PW(PW), .DW(DW)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .f_start    (f_start),
    .f_stop     (f_stop),
    .f_step     (f_step),
    .dwell      (dwell),
    .p_offset   (p_offset),
    .Fword      (Fword),
    .Pword      (Pword),
    .busy       (busy),
    .step_tick  (step_tick),
    .sweep_done (sweep_done),
    .cfg_err    (cfg_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // compare Fword/step_tick/sweep_done/busy at the current sample point
  task automatic chk_out(input string tag, input logic [FW-1:0] f, input logic tk,
                         input logic dn, input logic bz);
    chk({tag, ".Fword"}, 64'(Fword), 64'(f));
    chk({tag, ".step_tick"}, 64'(step_tick), 64'(tk));
    chk({tag, ".sweep_done"}, 64'(sweep_done), 64'(dn));
    chk({tag, ".busy"}, 64'(busy), 64'(bz));
  endtask

  task automatic edge1();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic st(input string tag, input logic [FW-1:0] f, input logic tk,
                    input logic dn, input logic bz);
    edge1();
    chk_out(tag, f, tk, dn, bz);
  endtask

  task automatic launch(input logic [FW-1:0] fs, input logic [FW-1:0] fe,
                        input logic [FW-1:0] stp, input logic [DW-1:0] dw,
                        input logic [1:0] md);
    f_start = fs;
    f_stop  = fe;
    f_step  = stp;
    dwell   = dw;
    mode    = md;
    start   = 1'b1;
    edge1();
    start   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0; p_offset = 12'h123;
    repeat (2) edge1();
    chk_out("reset", 32'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.Pword", 64'(Pword), 64'h0);
    chk("reset.cfg_err", 64'(cfg_err), 64'h0);
    rst = 1'b0;
    edge1();
    chk("pword_copy", 64'(Pword), 64'h123);

    // single sweep 100..130 step 10, dwell 3
    launch(32'd100, 32'd130, 32'd10, 24'd3, 2'b00);
    chk_out("single.ld", 32'd100, 1'b0, 1'b0, 1'b1);
    st("single.1", 32'd100, 1'b0, 1'b0, 1'b1);
    st("single.2", 32'd100, 1'b0, 1'b0, 1'b1);
    st("single.3", 32'd110, 1'b1, 1'b0, 1'b1);
    st("single.4", 32'd110, 1'b0, 1'b0, 1'b1);
    st("single.5", 32'd110, 1'b0, 1'b0, 1'b1);
    st("single.6", 32'd120, 1'b1, 1'b0, 1'b1);
    st("single.7", 32'd120, 1'b0, 1'b0, 1'b1);
    st("single.8", 32'd120, 1'b0, 1'b0, 1'b1);
    st("single.9", 32'd130, 1'b1, 1'b1, 1'b1);
    st("single.10", 32'd130, 1'b0, 1'b0, 1'b0);
    st("single.11", 32'd130, 1'b0, 1'b0, 1'b0);

    // clamp to f_stop with dwell 0 acting as 1
    launch(32'd0, 32'd25, 32'd10, 24'd0, 2'b00);
    chk_out("clamp.ld", 32'd0, 1'b0, 1'b0, 1'b1);
    st("clamp.1", 32'd10, 1'b1, 1'b0, 1'b1);
    st("clamp.2", 32'd20, 1'b1, 1'b0, 1'b1);
    st("clamp.3", 32'd25, 1'b1, 1'b1, 1'b1);
    st("clamp.4", 32'd25, 1'b0, 1'b0, 1'b0);

    // overflow guard near the top of the word range
    launch(32'hFFFF_FF00, 32'hFFFF_FFF0, 32'h80, 24'd1, 2'b00);
    chk_out("ovf.ld", 32'hFFFF_FF00, 1'b0, 1'b0, 1'b1);
    st("ovf.1", 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1);
    st("ovf.2", 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b1);
    st("ovf.3", 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);

    // triangle 0..20 step 10, dwell 1
    launch(32'd0, 32'd20, 32'd10, 24'd1, 2'b10);
    chk_out("tri.ld", 32'd0, 1'b0, 1'b0, 1'b1);
    st("tri.1", 32'd10, 1'b1, 1'b0, 1'b1);
    st("tri.2", 32'd20, 1'b1, 1'b0, 1'b1);
    st("tri.3", 32'd10, 1'b1, 1'b0, 1'b1);
    st("tri.4", 32'd0, 1'b1, 1'b1, 1'b1);
    // a start while busy must be ignored
    f_start = 32'd500; f_stop = 32'd900; start = 1'b1;
    st("tri.5", 32'd10, 1'b1, 1'b0, 1'b1);
    start = 1'b0;
    st("tri.6", 32'd20, 1'b1, 1'b0, 1'b1);
    st("tri.7", 32'd10, 1'b1, 1'b0, 1'b1);
    st("tri.8", 32'd0, 1'b1, 1'b1, 1'b1);
    abort = 1'b1;
    st("tri.abort", 32'd0, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;

    // abort coinciding with a dwell expiry at 110
    launch(32'd100, 32'd130, 32'd10, 24'd2, 2'b00);
    chk_out("abort.ld", 32'd100, 1'b0, 1'b0, 1'b1);
    st("abort.1", 32'd100, 1'b0, 1'b0, 1'b1);
    st("abort.2", 32'd110, 1'b1, 1'b0, 1'b1);
    st("abort.3", 32'd110, 1'b0, 1'b0, 1'b1);
    abort = 1'b1;
    st("abort.4", 32'd110, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    st("abort.5", 32'd110, 1'b0, 1'b0, 1'b0);

    // rejected start: f_stop == f_start
    launch(32'd50, 32'd50, 32'd10, 24'd1, 2'b00);
    chk("reject.cfg_err", 64'(cfg_err), 64'h1);
    chk_out("reject", 32'd110, 1'b0, 1'b0, 1'b0);
    edge1();
    chk("reject.cfg_err_clr", 64'(cfg_err), 64'h0);
    chk("reject.busy", 64'(busy), 64'h0);

    // zero step: word parks at f_start, no ticks, until aborted
    launch(32'd10, 32'd20, 32'd0, 24'd0, 2'b00);
    st("zstep.1", 32'd10, 1'b0, 1'b0, 1'b1);
    st("zstep.2", 32'd10, 1'b0, 1'b0, 1'b1);
    st("zstep.3", 32'd10, 1'b0, 1'b0, 1'b1);
    abort = 1'b1;
    st("zstep.abort", 32'd10, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;

    // sawtooth, then reset mid-sweep
    p_offset = 12'hABC;
    launch(32'd0, 32'd20, 32'd10, 24'd1, 2'b01);
    chk_out("saw.ld", 32'd0, 1'b0, 1'b0, 1'b1);
    chk("saw.Pword", 64'(Pword), 64'hABC);
    st("saw.1", 32'd10, 1'b1, 1'b0, 1'b1);
    st("saw.2", 32'd20, 1'b1, 1'b1, 1'b1);
    st("saw.3", 32'd0, 1'b1, 1'b0, 1'b1);
    st("saw.4", 32'd10, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    st("saw.rst", 32'd0, 1'b0, 1'b0, 1'b0);
    chk("saw.rst.Pword", 64'(Pword), 64'h0);
    rst = 1'b0;
    launch(32'd100, 32'd130, 32'd10, 24'd0, 2'b00);
    chk_out("post.ld", 32'd100, 1'b0, 1'b0, 1'b1);
    chk("post.Pword", 64'(Pword), 64'hABC);
    st("post.1", 32'd110, 1'b1, 1'b0, 1'b1);
    st("post.2", 32'd120, 1'b1, 1'b0, 1'b1);
    st("post.3", 32'd130, 1'b1, 1'b1, 1'b1);
    st("post.4", 32'd130, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
